// File: rtl/ise_seq_pkg.sv
// Shared definitions for the image sorting engine sequencer: state encoding,
// default geometry and a counter-width helper.
package ise_seq_pkg;

    localparam int IMG_NUM_DEF     = 32;
    localparam int PIX_PER_IMG_DEF = 16384;
    localparam int IDX_W_DEF       = 5;

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_CLS  = 3'd1,
        ST_SORT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ise_seq_cnt.sv
// Up-counter that stops at a terminal value and flags it. Clear wins over
// increment; an increment while at the terminal value holds the count.
module ise_seq_cnt #(
    parameter int W    = 4,
    parameter int LAST = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_last
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    assign at_last = (count == LAST_V);

    // Count register: reset/clear to zero, otherwise saturating increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !at_last) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ise_seq.sv
// Top-level sequencer for the image sorting engine. Gates pixel intake per
// image, kicks per-image classification, then the sort pass, then streams
// the sorted result table addresses out. All arithmetic lives in the datapath.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | accepting pixels of image cur_img, one per cycle while !busy
// ST_CLS  | waiting for the datapath to classify image cur_img
// ST_SORT | waiting for the datapath to sort the result table
// ST_EMIT | presenting rd_addr 0..IMG_NUM-1 with out_valid
// ST_DONE | run complete; parked until reset
module ise_seq
    import ise_seq_pkg::*;
#(
    parameter int IMG_NUM     = IMG_NUM_DEF,
    parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] image_in_index,
    output logic             busy,
    output logic             pix_we,
    output logic             pix_first,
    output logic             pix_last,
    output logic [IDX_W-1:0] cur_img,
    output logic             cls_start,
    input  logic             cls_done,
    output logic             sort_start,
    input  logic             sort_done,
    output logic             out_valid,
    output logic [IDX_W-1:0] rd_addr,
    output logic             done,
    output logic             seq_err
);

    localparam int PIX_W = cnt_width(PIX_PER_IMG);

    state_t state_q, state_d;

    logic             busy_q;
    logic             out_valid_q;
    logic             cls_start_q;
    logic             sort_start_q;
    logic             seq_err_q;

    logic [PIX_W-1:0] pix_cnt;
    logic             pix_at_last;
    logic             pix_inc, pix_clr;

    logic [IDX_W-1:0] img_cnt;
    logic             img_at_last;
    logic             img_inc;

    logic [IDX_W-1:0] rd_cnt;
    logic             rd_at_last;
    logic             rd_inc, rd_clr;

    logic             pix_we_c;

    ise_seq_cnt #(.W(PIX_W), .LAST(PIX_PER_IMG - 1)) u_pix_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (pix_clr),
        .inc     (pix_inc),
        .count   (pix_cnt),
        .at_last (pix_at_last)
    );

    // The image counter is only ever cleared by reset: a run never revisits
    // an earlier image.
    ise_seq_cnt #(.W(IDX_W), .LAST(IMG_NUM - 1)) u_img_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (1'b0),
        .inc     (img_inc),
        .count   (img_cnt),
        .at_last (img_at_last)
    );

    ise_seq_cnt #(.W(IDX_W), .LAST(IMG_NUM - 1)) u_rd_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (rd_clr),
        .inc     (rd_inc),
        .count   (rd_cnt),
        .at_last (rd_at_last)
    );

    // Next-state and counter controls. The last pixel moves straight to
    // ST_CLS on the same edge that raises busy, so no pixel is taken in the
    // cycle after it. Done strobes are only looked at in their own wait state.
    always_comb begin
        state_d  = state_q;
        pix_we_c = 1'b0;
        pix_inc  = 1'b0;
        pix_clr  = 1'b0;
        img_inc  = 1'b0;
        rd_inc   = 1'b0;
        rd_clr   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (!busy_q) begin
                    pix_we_c = 1'b1;
                    if (pix_at_last) begin
                        pix_clr = 1'b1;
                        state_d = ST_CLS;
                    end else begin
                        pix_inc = 1'b1;
                    end
                end
            end
            ST_CLS: begin
                if (cls_done) begin
                    if (img_at_last) begin
                        state_d = ST_SORT;
                    end else begin
                        img_inc = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SORT: begin
                if (sort_done) begin
                    rd_clr  = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rd_at_last) begin
                    state_d = ST_DONE;
                end else begin
                    rd_inc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and registered handshake outputs. Start pulses fire on the first
    // cycle of their wait state; busy and out_valid track the state entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            cls_start_q  <= 1'b0;
            sort_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != ST_LOAD);
            out_valid_q  <= (state_d == ST_EMIT);
            cls_start_q  <= (state_d == ST_CLS)  && (state_q != ST_CLS);
            sort_start_q <= (state_d == ST_SORT) && (state_q != ST_SORT);
        end
    end

    // Sticky host sequencing error; it is only reported, never acted on.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_err_q <= 1'b0;
        end else if (pix_first && (image_in_index != img_cnt)) begin
            seq_err_q <= 1'b1;
        end
    end

    assign pix_we     = pix_we_c;
    assign pix_first  = pix_we_c && (pix_cnt == '0);
    assign pix_last   = pix_we_c && pix_at_last;
    assign busy       = busy_q;
    assign cur_img    = img_cnt;
    assign cls_start  = cls_start_q;
    assign sort_start = sort_start_q;
    assign out_valid  = out_valid_q;
    assign rd_addr    = rd_cnt;
    assign done       = (state_q == ST_DONE);
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_ise_seq.sv
// Scoreboard bench for ise_seq: each run pushes the full expected strobe
// sequence (with cycle spacing and expected seq_err), a monitor pops and
// compares whenever the DUT raises a strobe.
module tb_ise_seq;

    localparam int IMG_NUM = 4;
    localparam int PIX     = 8;
    localparam int IDX_W   = 2;
    localparam int NONE    = 99;

    localparam int K_PIX  = 0;
    localparam int K_CLS  = 1;
    localparam int K_SORT = 2;
    localparam int K_OUT  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [IDX_W-1:0] image_in_index;
    logic             cls_done, sort_done;
    logic             busy, pix_we, pix_first, pix_last;
    logic [IDX_W-1:0] cur_img, rd_addr;
    logic             cls_start, sort_start, out_valid, done, seq_err;

    always #5 clk = ~clk;

    ise_seq #(.IMG_NUM(IMG_NUM), .PIX_PER_IMG(PIX), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .image_in_index (image_in_index),
        .busy           (busy),
        .pix_we         (pix_we),
        .pix_first      (pix_first),
        .pix_last       (pix_last),
        .cur_img        (cur_img),
        .cls_start      (cls_start),
        .cls_done       (cls_done),
        .sort_start     (sort_start),
        .sort_done      (sort_done),
        .out_valid      (out_valid),
        .rd_addr        (rd_addr),
        .done           (done),
        .seq_err        (seq_err)
    );

    typedef struct {
        int kind;
        int first;
        int last;
        int idx;
        int err;
        int delta;
    } ev_t;

    ev_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_ev_cyc = 0;
    bit prev_last   = 1'b0;

    // datapath / host model configuration
    int lat[IMG_NUM];
    int slat     = 5;
    int mm       = NONE;
    bit spur     = 1'b0;
    bit tied     = 1'b0;
    int tb_img   = 0;
    bit cls_pend = 1'b0;
    bit s_pend   = 1'b0;
    int cls_wait = 0;
    int s_wait   = 0;
    int exp_err_end = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int first, input int last,
                           input int idx, input int err, input int delta);
        ev_t e;
        e.kind  = kind;
        e.first = first;
        e.last  = last;
        e.idx   = idx;
        e.err   = err;
        e.delta = delta;
        exp_q.push_back(e);
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a;
        lat[1] = b;
        lat[2] = c;
        lat[3] = d;
    endtask

    // Reference model: the whole run as a list of strobes. Spacing follows
    // from the handshake rules: a pixel per cycle, cls_start one cycle after
    // the last pixel, next image L+1 cycles after cls_start (L = cls_done
    // latency), sort_start L+1 after the last cls_start, first output S+1
    // after sort_start. delta 0 means "not checked".
    task automatic start_run(input int s, input int m, input bit sp, input bit td);
        int err;
        err = 0;
        for (int i = 0; i < IMG_NUM; i++) begin
            for (int p = 0; p < PIX; p++) begin
                push_ev(K_PIX, (p == 0) ? 1 : 0, (p == PIX - 1) ? 1 : 0, i, err,
                        (p > 0) ? 1 : ((i == 0) ? 0 : lat[i-1] + 1));
                if (p == 0 && i == m) err = 1;
            end
            push_ev(K_CLS, 0, 0, i, err, 1);
        end
        push_ev(K_SORT, 0, 0, IMG_NUM - 1, err, lat[IMG_NUM-1] + 1);
        for (int a = 0; a < IMG_NUM; a++) begin
            push_ev(K_OUT, 0, 0, a, err, (a == 0) ? s + 1 : 1);
        end
        exp_err_end = err;
        slat = s;
        mm   = m;
        spur = sp;
        tied = td;
    endtask

    // Assert reset for one edge from now, then check the reset state.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        cls_pend    = 1'b0;
        s_pend      = 1'b0;
        tb_img      = 0;
        spur        = 1'b0;
        tied        = 1'b0;
        mm          = NONE;
        prev_last   = 1'b0;
        last_ev_cyc = cyc;
        chk("rst_busy",       int'(busy),       0);
        chk("rst_out_valid",  int'(out_valid),  0);
        chk("rst_done",       int'(done),       0);
        chk("rst_cur_img",    int'(cur_img),    0);
        chk("rst_rd_addr",    int'(rd_addr),    0);
        chk("rst_seq_err",    int'(seq_err),    0);
        chk("rst_cls_start",  int'(cls_start),  0);
        chk("rst_sort_start", int'(sort_start), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_done",        int'(done),      1);
        chk("end_busy",        int'(busy),      1);
        chk("end_out_valid",   int'(out_valid), 0);
        chk("end_seq_err",     int'(seq_err),   exp_err_end);
        chk("events_left",     exp_q.size(),    0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky",     int'(done),      1);
        chk("done_no_pix",     int'(pix_we),    0);
    endtask

    // Datapath and host model, acting just after each edge.
    initial begin
        cls_done       = 1'b0;
        sort_done      = 1'b0;
        image_in_index = '0;
        forever begin
            @(posedge clk);
            #2;
            cls_done  = tied;
            sort_done = 1'b0;
            if (cls_start) begin
                cls_pend = 1'b1;
                cls_wait = (tb_img < IMG_NUM) ? lat[tb_img] : 0;
                tb_img++;
            end
            if (cls_pend) begin
                if (cls_wait == 0) begin
                    cls_done = 1'b1;
                    cls_pend = 1'b0;
                end else begin
                    cls_wait--;
                end
            end
            if (sort_start) begin
                s_pend = 1'b1;
                s_wait = slat;
            end
            if (s_pend) begin
                if (s_wait == 0) begin
                    sort_done = 1'b1;
                    s_pend    = 1'b0;
                end else begin
                    s_wait--;
                end
            end
            if (spur && !busy) begin
                if ($urandom_range(0, 2) == 0) cls_done = 1'b1;
                if ($urandom_range(0, 2) == 0) sort_done = 1'b1;
            end
            image_in_index = IDX_W'(tb_img + ((tb_img == mm) ? 1 : 0));
        end
    end

    // Monitor: compare every strobe against the scoreboard head.
    initial begin
        int  nact;
        ev_t a;
        ev_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (prev_last) begin
                    chk("busy_after_last",   int'(busy),   1);
                    chk("pix_we_after_last", int'(pix_we), 0);
                end
                prev_last = pix_we && pix_last;
                nact = int'(pix_we) + int'(cls_start) + int'(sort_start) + int'(out_valid);
                if (nact > 1) begin
                    chk("strobe_overlap", nact, 1);
                end else if (nact == 1) begin
                    a.kind  = pix_we ? K_PIX : (cls_start ? K_CLS : (sort_start ? K_SORT : K_OUT));
                    a.first = int'(pix_first);
                    a.last  = int'(pix_last);
                    a.idx   = out_valid ? int'(rd_addr) : int'(cur_img);
                    a.err   = int'(seq_err);
                    a.delta = cyc - last_ev_cyc;
                    last_ev_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind",  a.kind,  e.kind);
                        chk("ev_first", a.first, e.first);
                        chk("ev_last",  a.last,  e.last);
                        chk("ev_index", a.idx,   e.idx);
                        chk("ev_seq_err", a.err, e.err);
                        if (e.delta != 0) chk("ev_spacing", a.delta, e.delta);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit td;

        // nominal
        set_lat(3, 3, 3, 3);
        do_reset();
        start_run(5, NONE, 1'b0, 1'b0);
        wait_done();

        // cls_done tied high
        set_lat(0, 0, 0, 0);
        do_reset();
        start_run(5, NONE, 1'b0, 1'b1);
        wait_done();

        // spurious done strobes during LOAD
        set_lat(3, 3, 3, 3);
        do_reset();
        start_run(5, NONE, 1'b1, 1'b0);
        wait_done();

        // wrong index on first pixel of image 1
        do_reset();
        start_run(5, 1, 1'b0, 1'b0);
        wait_done();

        // reset in SORT
        do_reset();
        start_run(5, NONE, 1'b0, 1'b0);
        n = 0;
        while (!sort_start && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_sort", int'(sort_start), 1);
        do_reset();

        // reset on the third EMIT cycle
        start_run(5, NONE, 1'b0, 1'b0);
        n = 0;
        while (!(out_valid && rd_addr == 2'd2) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_emit3", int'(rd_addr), 2);
        do_reset();
        start_run(5, NONE, 1'b0, 1'b0);
        wait_done();

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            td = ($urandom_range(0, 3) == 0);
            if (td) set_lat(0, 0, 0, 0);
            else set_lat($urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 4));
            do_reset();
            start_run($urandom_range(0, 6), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), td);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
